// File: rtl/uart_tx_arb_if.sv
// Two-requester UART transmit arbiter bundle: requester push ports, transmitter
// side signals, and observation of the arbiter FSM state and FIFO fill levels.
interface uart_tx_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_WIDTH-1:0]       req0_data;
  logic                        req0_valid;
  logic                        req0_ready;
  logic [DATA_WIDTH-1:0]       req1_data;
  logic                        req1_valid;
  logic                        req1_ready;
  logic                        tx_busy;
  logic [DATA_WIDTH-1:0]       tx_p_data;
  logic                        tx_data_valid;
  logic                        grant_id;
  logic                        frame_active;
  logic [1:0]                  dbg_state;
  logic [$clog2(FIFO_DEPTH):0] count0;
  logic [$clog2(FIFO_DEPTH):0] count1;

  modport slave (
    input  req0_data, req0_valid, req1_data, req1_valid, tx_busy,
    output req0_ready, req1_ready, tx_p_data, tx_data_valid, grant_id,
           frame_active, dbg_state, count0, count1
  );

  modport master (
    output req0_data, req0_valid, req1_data, req1_valid, tx_busy,
    input  req0_ready, req1_ready, tx_p_data, tx_data_valid, grant_id,
           frame_active, dbg_state, count0, count1
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter from two per-requester FIFOs,
// launching one character at a time and tracking the transmitter busy handshake.
module uart_tx_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_arb_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem0 [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [FIFO_DEPTH];
  logic [PW-1:0]         wr0, rd0, wr1, rd1;
  logic [CW-1:0]         cnt0, cnt1, cnt0_next, cnt1_next;
  logic                  ready0, ready1;
  logic                  push0, push1, pop0, pop1;
  logic                  sel;
  logic                  grant;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  // A character is transferred on every edge where valid and ready are both
  // high; ready is registered and never depends on valid in the same cycle.
  assign push0 = bus.req0_valid & ready0;
  assign push1 = bus.req1_valid & ready1;

  always_comb begin
    state_next = state;
    pop0       = 1'b0;
    pop1       = 1'b0;
    sel        = grant;
    case (state)
      IDLE: begin
        if (!bus.tx_busy && (cnt0 != '0 || cnt1 != '0)) begin
          state_next = LAUNCH;
          // With both pending, the requester that did not go last wins.
          if (cnt0 != '0 && cnt1 != '0) sel = ~grant;
          else                          sel = (cnt0 == '0);
          pop0 = ~sel;
          pop1 = sel;
        end
      end
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy)  state_next = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign cnt0_next = cnt0 + CW'(push0) - CW'(pop0);
  assign cnt1_next = cnt1 + CW'(push1) - CW'(pop1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr0    <= '0;
      rd0    <= '0;
      wr1    <= '0;
      rd1    <= '0;
      cnt0   <= '0;
      cnt1   <= '0;
      ready0 <= 1'b0;
      ready1 <= 1'b0;
    end else begin
      if (push0) begin
        mem0[wr0] <= bus.req0_data;
        wr0       <= wr0 + PW'(1);
      end
      if (push1) begin
        mem1[wr1] <= bus.req1_data;
        wr1       <= wr1 + PW'(1);
      end
      if (pop0) rd0 <= rd0 + PW'(1);
      if (pop1) rd1 <= rd1 + PW'(1);
      cnt0   <= cnt0_next;
      cnt1   <= cnt1_next;
      ready0 <= (cnt0_next < DEPTH_C);
      ready1 <= (cnt1_next < DEPTH_C);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      grant   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_next == LAUNCH);
      if (pop0 || pop1) begin
        data_q <= sel ? mem1[rd1] : mem0[rd0];
        grant  <= sel;
      end
    end
  end

  assign bus.req0_ready    = ready0;
  assign bus.req1_ready    = ready1;
  assign bus.tx_p_data     = data_q;
  assign bus.tx_data_valid = valid_q;
  assign bus.grant_id      = grant;
  assign bus.frame_active  = (state != IDLE);
  assign bus.dbg_state     = state;
  assign bus.count0        = cnt0;
  assign bus.count1        = cnt1;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a launch scoreboard fed at push time, a table of single
// character transfers, and directed sequences for the multi-cycle corner cases.
module tb_uart_tx_arb;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus();

  uart_tx_arb #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic model_en   = 1'b0;
  logic busy_force = 1'b0;
  logic busy_model = 1'b0;
  int   frame_len  = 3;
  int   busy_cnt   = 0;
  assign bus.tx_busy = model_en ? busy_model : busy_force;

  int total   = 0;
  int bad     = 0;
  int strobes = 0;
  logic [DW:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy for frame_len cycles after each launch strobe.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt   = 0;
      busy_model = 1'b0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (bus.tx_data_valid) busy_cnt = frame_len;
      busy_model = (busy_cnt > 0);
    end
  end

  // Scoreboard: every launch strobe must match the oldest expected {grant, data}.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst_n && bus.tx_data_valid) begin
      strobes++;
      check("strobe_frame_active", bus.frame_active, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", bus.tx_p_data, 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("launch_data", bus.tx_p_data, e[DW-1:0]);
        check("launch_grant", bus.grant_id, e[DW]);
      end
    end
  end

  // driver tasks
  task automatic push(input bit r, input logic [DW-1:0] d, output bit acc);
    if (r) begin
      bus.req1_data  = d;
      bus.req1_valid = 1'b1;
      acc            = bus.req1_ready;
    end else begin
      bus.req0_data  = d;
      bus.req0_valid = 1'b1;
      acc            = bus.req0_ready;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.dbg_state != ST_IDLE ||
            bus.count0 != '0 || bus.count1 != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  typedef struct {
    bit            req;
    logic [DW-1:0] data;
    bit            exp_grant;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    bit   acc;
    bit   exp_acc;
    bit   stuck_ok;
    int   base;
    int   mcnt;
    logic [DW-1:0] d;

    vecs[0] = '{req: 1'b1, data: 8'h5A, exp_grant: 1'b1};
    vecs[1] = '{req: 1'b0, data: 8'h00, exp_grant: 1'b0};
    vecs[2] = '{req: 1'b1, data: 8'hFF, exp_grant: 1'b1};
    vecs[3] = '{req: 1'b0, data: 8'hC3, exp_grant: 1'b0};
    vecs[4] = '{req: 1'b1, data: 8'h3C, exp_grant: 1'b1};

    bus.req0_data  = '0;
    bus.req0_valid = 1'b0;
    bus.req1_data  = '0;
    bus.req1_valid = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_tx_p_data", bus.tx_p_data, 0);
    check("rst_valid", bus.tx_data_valid, 0);
    check("rst_frame_active", bus.frame_active, 0);
    check("rst_grant", bus.grant_id, 1);
    check("rst_state", bus.dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready0", bus.req0_ready, 1);
    check("post_rst_ready1", bus.req1_ready, 1);

    // single push 0xA5 on requester 0: launch two edges after the push
    frame_len = 3;
    model_en  = 1'b1;
    exp_q.push_back({1'b0, 8'hA5});
    push(1'b0, 8'hA5, acc);
    check("s1_accept", acc, 1);
    check("s1_edge_n_valid", bus.tx_data_valid, 0);
    check("s1_edge_n_state", bus.dbg_state, ST_IDLE);
    check("s1_edge_n_count0", bus.count0, 1);
    @(negedge clk);
    check("s1_launch_valid", bus.tx_data_valid, 1);
    check("s1_launch_data", bus.tx_p_data, 8'hA5);
    check("s1_launch_grant", bus.grant_id, 0);
    check("s1_launch_state", bus.dbg_state, ST_LAUNCH);
    @(negedge clk);
    check("s1_one_cycle_strobe", bus.tx_data_valid, 0);
    check("s1_wait_busy", bus.dbg_state, ST_WAIT_BUSY);
    check("s1_data_hold", bus.tx_p_data, 8'hA5);
    wait_drain(100, "s1_drain");

    // table of single transfers alternating requesters
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({vecs[i].exp_grant, vecs[i].data});
      push(vecs[i].req, vecs[i].data, acc);
      check("tbl_accept", acc, 1);
      wait_drain(100, "tbl_drain");
    end

    // preload both FIFOs, then round-robin with an 11-cycle transmitter
    model_en   = 1'b0;
    busy_force = 1'b1;
    push(1'b0, 8'h11, acc); check("s2_acc_11", acc, 1);
    push(1'b0, 8'h22, acc); check("s2_acc_22", acc, 1);
    push(1'b1, 8'h33, acc); check("s2_acc_33", acc, 1);
    push(1'b1, 8'h44, acc); check("s2_acc_44", acc, 1);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h33});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h44});
    check("s2_preload_idle", bus.dbg_state, ST_IDLE);
    base      = strobes;
    frame_len = 11;
    model_en  = 1'b1;
    wait_drain(300, "s2_drain");
    check("s2_strobe_count", strobes - base, 4);

    // five back-to-back pushes on requester 1 while the transmitter is busy
    model_en   = 1'b0;
    busy_force = 1'b1;
    mcnt       = 0;
    for (int i = 0; i < 5; i++) begin
      exp_acc = (mcnt < DEPTH);
      d       = 8'(8'hB0 + i);
      push(1'b1, d, acc);
      check("s3_accept", acc, exp_acc);
      if (exp_acc) begin
        mcnt++;
        exp_q.push_back({1'b1, d});
      end
    end
    check("s3_count1", bus.count1, 4);
    check("s3_ready1", bus.req1_ready, 0);
    check("s3_ready0", bus.req0_ready, 1);
    frame_len = 3;
    model_en  = 1'b1;
    wait_drain(200, "s3_drain");

    // transmitter never raises busy: arbiter must park in WAIT_BUSY
    model_en   = 1'b0;
    busy_force = 1'b0;
    base       = strobes;
    exp_q.push_back({1'b0, 8'hD4});
    push(1'b0, 8'hD4, acc);
    check("s4_accept", acc, 1);
    @(negedge clk);
    check("s4_launch_state", bus.dbg_state, ST_LAUNCH);
    stuck_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.dbg_state != ST_WAIT_BUSY || bus.tx_data_valid) stuck_ok = 1'b0;
    end
    check("s4_stuck_wait_busy", stuck_ok, 1);
    check("s4_single_strobe", strobes - base, 1);
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    busy_force = 1'b0;
    wait_drain(100, "s4_drain");

    // simultaneous push and pop on requester 0 with count 2
    model_en   = 1'b0;
    busy_force = 1'b1;
    exp_q.push_back({1'b0, 8'h61});
    exp_q.push_back({1'b0, 8'h62});
    exp_q.push_back({1'b0, 8'h63});
    push(1'b0, 8'h61, acc);
    push(1'b0, 8'h62, acc);
    check("s5_count_before", bus.count0, 2);
    busy_force = 1'b0;
    push(1'b0, 8'h63, acc);
    busy_force = 1'b1;
    check("s5_accept", acc, 1);
    check("s5_count_kept", bus.count0, 2);
    check("s5_state", bus.dbg_state, ST_LAUNCH);
    check("s5_head_data", bus.tx_p_data, 8'h61);
    repeat (2) @(negedge clk);
    model_en = 1'b1;
    wait_drain(200, "s5_drain");

    // reset in WAIT_DONE with three entries queued on each requester
    model_en   = 1'b0;
    busy_force = 1'b0;
    exp_q.push_back({1'b0, 8'h70});
    push(1'b0, 8'h70, acc);
    @(negedge clk);
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    push(1'b0, 8'h71, acc);
    push(1'b0, 8'h72, acc);
    push(1'b0, 8'h73, acc);
    push(1'b1, 8'h81, acc);
    push(1'b1, 8'h82, acc);
    push(1'b1, 8'h83, acc);
    check("s6_state_wait_done", bus.dbg_state, ST_WAIT_DONE);
    check("s6_count0", bus.count0, 3);
    check("s6_count1", bus.count1, 3);
    rst_n = 1'b0;
    #1;
    check("s6_rst_state", bus.dbg_state, ST_IDLE);
    check("s6_rst_valid", bus.tx_data_valid, 0);
    check("s6_rst_data", bus.tx_p_data, 0);
    check("s6_rst_grant", bus.grant_id, 1);
    check("s6_rst_frame_active", bus.frame_active, 0);
    check("s6_rst_ready0", bus.req0_ready, 0);
    check("s6_rst_ready1", bus.req1_ready, 0);
    check("s6_rst_count0", bus.count0, 0);
    check("s6_rst_count1", bus.count1, 0);
    @(negedge clk);
    rst_n      = 1'b1;
    busy_force = 1'b0;
    base       = strobes;
    repeat (30) @(negedge clk);
    check("s6_no_strobe", strobes - base, 0);
    check("s6_idle_after", bus.dbg_state, ST_IDLE);
    check("s6_ready0_after", bus.req0_ready, 1);
    check("s6_ready1_after", bus.req1_ready, 1);

    // final report
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the character data on every data port.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the entries per requester FIFO; legal values are powers of two from 2 to 16.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-004 RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 REQ0_DATA  input  DATA_WIDTH  SHALL be the requester-0 character.
REQ-006 REQ0_VALID  input  1  SHALL be the requester-0 push request.
REQ-007 REQ0_READY  output  1  SHALL indicate that the requester-0 FIFO accepts a push this cycle.
REQ-008 REQ1_DATA, REQ1_VALID, REQ1_READY SHALL be the requester-1 equivalents of REQ-005 to REQ-007.
REQ-009 TX_BUSY  input  1  SHALL be the busy indication from the UART transmitter.
REQ-010 TX_P_DATA  output  DATA_WIDTH  SHALL be the registered character driven to the UART transmitter.
REQ-011 TX_DATA_VALID  output  1  SHALL be a registered one-cycle launch strobe to the UART transmitter.
REQ-012 GRANT_ID  output  1  SHALL identify the requester whose character was most recently launched.
REQ-013 FRAME_ACTIVE  output  1  SHALL be high in every state except IDLE.

Function
REQ-014 A push SHALL occur on a cycle where REQn_VALID=1 and REQn_READY=1; data SHALL be written at the write pointer, which then increments and wraps modulo FIFO_DEPTH.
REQ-015 REQn_READY SHALL be a registered signal equal to (countn < FIFO_DEPTH); it SHALL be low when the FIFO is full, and any push attempted while READY=0 SHALL be ignored.
REQ-016 A pop SHALL occur only on the IDLE->LAUNCH transition; a simultaneous push and pop on one FIFO SHALL leave its count unchanged.
REQ-017 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-018 IDLE: when TX_BUSY=0 and at least one FIFO is non-empty, the FSM SHALL select a requester, pop its head into TX_P_DATA, update GRANT_ID, and go to LAUNCH; otherwise it SHALL remain in IDLE.
REQ-019 LAUNCH: TX_DATA_VALID SHALL be 1 for exactly this one cycle, and the FSM SHALL then go to WAIT_BUSY unconditionally.
REQ-020 WAIT_BUSY: the FSM SHALL go to WAIT_DONE when TX_BUSY=1; otherwise it SHALL remain in WAIT_BUSY.
REQ-021 WAIT_DONE: the FSM SHALL go to IDLE when TX_BUSY=0; otherwise it SHALL remain in WAIT_DONE.
REQ-022 Arbitration SHALL follow these rules:
- Only one FIFO non-empty: that FIFO is selected.
- Both non-empty: the requester not equal to GRANT_ID is selected (round-robin).
REQ-023 TX_P_DATA SHALL hold its value from LAUNCH until the next IDLE->LAUNCH transition.
REQ-024 Latency, with the FSM in IDLE, TX_BUSY=0 and both FIFOs empty:
- Push accepted at edge N.
- IDLE->LAUNCH decision at edge N+1.
- TX_DATA_VALID high during the cycle following edge N+1.
REQ-025 At most one character SHALL be outstanding at the transmitter; no launch SHALL occur while FRAME_ACTIVE=1.
REQ-026 The FIFO counters SHALL be $clog2(FIFO_DEPTH)+1 bits wide and SHALL never underflow or overflow.

Reset
REQ-027 While RST=0, all of the following SHALL hold:
- State = IDLE; all FIFO pointers and counts = 0.
- REQ0_READY = REQ1_READY = 0 during reset, and 1 on the first edge after release.
- TX_P_DATA = 0; TX_DATA_VALID = 0; FRAME_ACTIVE = 0.
- GRANT_ID = 1, so that requester 0 wins the first contention.
REQ-028 Reset asserted mid-frame SHALL immediately force the state in REQ-027 and discard all queued characters; no TX_DATA_VALID SHALL follow release until a new push occurs.

Verification
REQ-029 The bench SHALL cover at least these six directed scenarios:
- Single push 0xA5 on requester 0 with TX_BUSY=0 -> TX_P_DATA=0xA5, TX_DATA_VALID one cycle high two edges after the push, GRANT_ID=0.
- Both FIFOs preloaded with 0x11,0x22 (req0) and 0x33,0x44 (req1), TX_BUSY modelled as 11 cycles per frame -> launch order 0x11, 0x33, 0x22, 0x44, one strobe per frame.
- Five back-to-back pushes on requester 1 while TX_BUSY is held at 1 -> four accepted, REQ1_READY=0 after the fourth, fifth ignored, count=4.
- TX_BUSY held at 0 for 20 cycles after LAUNCH -> FSM stays in WAIT_BUSY, no second strobe.
- Push and pop on the same cycle with count=2 -> count stays 2, and the popped data is the FIFO head.
- RST pulsed low while in WAIT_DONE with both FIFOs holding 3 entries -> all outputs at their reset values, and no strobe after release without new pushes.
